// File: rtl/mc_path_core.sv
// One Monte Carlo pricing lane: sweeps T timesteps, accumulating mu[t] * expSigma[path[t]]
// from double-buffered coefficient banks into a wrapping fixed-point sum.
module mc_path_core #(
    parameter int N         = 1,
    parameter int T         = 512,
    parameter int logT      = 9,
    parameter int pathWidth = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 iStart,
    input  logic                 iSwitch,
    input  logic [pathWidth-1:0] iSigmaWriteAddress,
    input  logic [17:0]          iSigmaWriteData,
    input  logic                 iSigmaWE,
    input  logic [logT-1:0]      iMuWriteAddress,
    input  logic [17:0]          iMuWriteData,
    input  logic                 iMuWE,
    input  logic [logT-1:0]      iPathWriteAddress,
    input  logic [pathWidth-1:0] iPathWriteData,
    input  logic                 iPathWE,
    output logic [18+logT-1:0]   oAcc,
    output logic                 oDone,
    output logic                 oBusy
);

    // state   | meaning
    // S_IDLE  | waiting for iStart, oAcc holds the last result
    // S_ISSUE | issuing timesteps t = 0..T-1, one per cycle
    // S_DRAIN | issuing stopped, waiting for the last product to be added

    localparam int AW = 18 + logT;

    if (T != (1 << logT) || N < 0) begin : g_bad_cfg
        $error("mc_path_core: T must equal 2**logT and N must be non-negative");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t state, state_nx;
    logic   busy, issue, start_ok, drain_end, last_t;
    logic   bank, wr_bank, wr_ok;
    logic   v1, v2, v3;

    logic [logT-1:0]      t;
    logic [pathWidth-1:0] path_q;
    logic [17:0]          mu_q, mu_d, sig_q, prod_q;
    logic [AW-1:0]        acc;

    logic [17:0]          sigma_mem [2][2**pathWidth];
    logic [17:0]          mu_mem    [2][T];
    logic [pathWidth-1:0] path_mem  [T];

    assign last_t    = (t == logT'(T - 1));
    assign drain_end = (state == S_DRAIN) && v3 && !v2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (iStart)    state_nx = S_ISSUE;
            S_ISSUE: if (last_t)    state_nx = S_DRAIN;
            S_DRAIN: if (drain_end) state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        issue    = (state == S_ISSUE);
        start_ok = (state == S_IDLE) && iStart;
    end

    // Host writes target the idle bank; the bank of an in-flight run is protected even if iSwitch flips.
    assign wr_bank = ~iSwitch;
    assign wr_ok   = !(busy && (wr_bank == bank));

    always_ff @(posedge CLK) begin
        if (iSigmaWE && wr_ok) sigma_mem[wr_bank][iSigmaWriteAddress] <= iSigmaWriteData;
        if (iMuWE && wr_ok)    mu_mem[wr_bank][iMuWriteAddress]       <= iMuWriteData;
        if (iPathWE && !busy)  path_mem[iPathWriteAddress]            <= iPathWriteData;
        path_q <= path_mem[t];
        mu_q   <= mu_mem[bank][t];
        sig_q  <= sigma_mem[bank][path_q];
        mu_d   <= mu_q;
        prod_q <= 18'((36'(sig_q) * 36'(mu_d)) >> 16);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            t     <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            bank  <= 1'b0;
            acc   <= '0;
            oDone <= 1'b0;
        end else begin
            v1    <= issue;
            v2    <= v1;
            v3    <= v2;
            oDone <= drain_end;
            if (start_ok) begin
                bank <= iSwitch;
                t    <= '0;
                acc  <= '0;
            end else begin
                if (issue) t <= t + 1'b1;
                if (v3)    acc <= acc + AW'(prod_q);
            end
        end
    end

    assign oAcc  = acc;
    assign oBusy = busy;

endmodule

// File: tb/tb_mc_path_core.sv
// Bench for mc_path_core: table of directed and random runs checked against a sum-of-products model.
module tb_mc_path_core;

    localparam int T    = 512;
    localparam int LOGT = 9;
    localparam int PW   = 10;
    localparam int AW   = 18 + LOGT;
    localparam int NS   = 1 << PW;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            iStart = 1'b0;
    logic            iSwitch = 1'b0;
    logic [PW-1:0]   iSigmaWriteAddress = '0;
    logic [17:0]     iSigmaWriteData = '0;
    logic            iSigmaWE = 1'b0;
    logic [LOGT-1:0] iMuWriteAddress = '0;
    logic [17:0]     iMuWriteData = '0;
    logic            iMuWE = 1'b0;
    logic [LOGT-1:0] iPathWriteAddress = '0;
    logic [PW-1:0]   iPathWriteData = '0;
    logic            iPathWE = 1'b0;
    logic [AW-1:0]   oAcc;
    logic            oDone;
    logic            oBusy;

    mc_path_core #(.N(1), .T(T), .logT(LOGT), .pathWidth(PW)) dut (
        .CLK(CLK), .RST_N(RST_N), .iStart(iStart), .iSwitch(iSwitch),
        .iSigmaWriteAddress(iSigmaWriteAddress), .iSigmaWriteData(iSigmaWriteData), .iSigmaWE(iSigmaWE),
        .iMuWriteAddress(iMuWriteAddress), .iMuWriteData(iMuWriteData), .iMuWE(iMuWE),
        .iPathWriteAddress(iPathWriteAddress), .iPathWriteData(iPathWriteData), .iPathWE(iPathWE),
        .oAcc(oAcc), .oDone(oDone), .oBusy(oBusy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference contents of both banks and the path table
    logic [17:0]   mu_m  [2][T];
    logic [17:0]   sig_m [2][NS];
    logic [PW-1:0] path_m[T];

    typedef struct {
        string         name;
        int            pat;
        bit            mid_wr;
        bit            mid_start;
        bit            has_const;
        logic [AW-1:0] acc_const;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [AW-1:0] model_acc(input int b);
        longint s = 0;
        for (int k = 0; k < T; k++) begin
            longint p = (longint'(mu_m[b][k]) * longint'(sig_m[b][path_m[k]])) / 65536;
            s += p % 262144;
        end
        return AW'(s);
    endfunction

    function automatic logic [17:0] gen_mu(input int p, input int i);
        case (p)
            0:       return 18'h08000;
            1:       return 18'(i);
            2:       return 18'h3FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    function automatic logic [17:0] gen_sig(input int p);
        case (p)
            0, 1:    return 18'h08000;
            2:       return 18'h3FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    function automatic logic [PW-1:0] gen_path(input int p, input int i);
        if (p <= 2) return PW'(i);
        return PW'($urandom);
    endfunction

    // Fill the bank the host owns under iSwitch=sw, plus the path table (only while idle)
    task automatic load(input int p, input logic sw);
        int wb;
        wb = sw ? 0 : 1;
        iSwitch = sw;
        for (int i = 0; i < NS; i++) begin
            logic [17:0]   ds, dm;
            logic [PW-1:0] dp;
            ds = gen_sig(p);
            iSigmaWE = 1'b1; iSigmaWriteAddress = PW'(i); iSigmaWriteData = ds;
            sig_m[wb][i] = ds;
            if (i < T) begin
                dm = gen_mu(p, i);
                dp = gen_path(p, i);
                iMuWE = 1'b1; iMuWriteAddress = LOGT'(i); iMuWriteData = dm;
                iPathWE = 1'b1; iPathWriteAddress = LOGT'(i); iPathWriteData = dp;
                mu_m[wb][i] = dm;
                path_m[i] = dp;
            end else begin
                iMuWE = 1'b0;
                iPathWE = 1'b0;
            end
            step();
        end
        iSigmaWE = 1'b0; iMuWE = 1'b0; iPathWE = 1'b0;
    endtask

    // One run reading bank sw; optional mid-run host writes / spurious start
    task automatic run(input string name, input logic sw, input bit mid_wr, input bit mid_start,
                       output logic [AW-1:0] req);
        int done_at;
        int pulses;
        req = model_acc(sw ? 1 : 0);
        done_at = -1;
        pulses = 0;
        iSwitch = sw;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        check({name, "_busy_start"}, 64'(oBusy), 64'd1);
        check({name, "_acc_cleared"}, 64'(oAcc), 64'd0);
        for (int c = 1; c <= T + 40; c++) begin
            iMuWE = 1'b0;
            if (mid_start) iStart = (c == 100);
            if (mid_wr) begin
                if (c <= 4) begin
                    // aimed at the in-flight bank 0: must be dropped
                    iSwitch = 1'b1; iMuWE = 1'b1;
                    iMuWriteAddress = LOGT'(T - c); iMuWriteData = 18'h3FFFF;
                end else if (c <= T + 4) begin
                    iSwitch = 1'b0; iMuWE = 1'b1;
                    iMuWriteAddress = LOGT'(c - 5); iMuWriteData = 18'h0;
                    mu_m[1][c-5] = 18'h0;
                end else begin
                    iSwitch = 1'b1;
                end
            end
            step();
            if (oDone) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = c;
                    check({name, "_busy_low_at_done"}, 64'(oBusy), 64'd0);
                end
            end
            if (done_at >= 0 && c >= done_at + 2) break;
        end
        iStart = 1'b0;
        iMuWE = 1'b0;
        check({name, "_done_latency"}, 64'(done_at), 64'(T + 3));
        check({name, "_done_pulses"}, 64'(pulses), 64'd1);
        check({name, "_acc_model"}, 64'(oAcc), 64'(req));
    endtask

    initial begin
        logic [AW-1:0] req;
        int pulses;

        vecs[0] = '{name: "unit",  pat: 0, mid_wr: 1'b1, mid_start: 1'b0, has_const: 1'b1, acc_const: AW'(27'h0800000)};
        vecs[1] = '{name: "ramp",  pat: 1, mid_wr: 1'b0, mid_start: 1'b1, has_const: 1'b1, acc_const: AW'(65280)};
        vecs[2] = '{name: "trunc", pat: 2, mid_wr: 1'b0, mid_start: 1'b0, has_const: 1'b1, acc_const: AW'(27'h7FFF000)};
        vecs[3] = '{name: "rand0", pat: 3, mid_wr: 1'b0, mid_start: 1'b0, has_const: 1'b0, acc_const: '0};
        vecs[4] = '{name: "rand1", pat: 3, mid_wr: 1'b0, mid_start: 1'b0, has_const: 1'b0, acc_const: '0};

        step();
        step();
        check("rst_acc", 64'(oAcc), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        check("rst_busy", 64'(oBusy), 64'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_acc", 64'(oAcc), 64'd0);
            check("idle_done", 64'(oDone), 64'd0);
            check("idle_busy", 64'(oBusy), 64'd0);
        end

        // bank1 gets defined contents before the double-buffer run reads it
        load(0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            load(vecs[v].pat, 1'b1);
            run(vecs[v].name, 1'b0, vecs[v].mid_wr, vecs[v].mid_start, req);
            if (vecs[v].has_const) check({vecs[v].name, "_acc_const"}, 64'(oAcc), 64'(vecs[v].acc_const));
            if (vecs[v].mid_wr) begin
                run("db_new_bank", 1'b1, 1'b0, 1'b0, req);
                check("db_new_bank_zero", 64'(oAcc), 64'd0);
            end
        end

        // reset in the middle of a run
        iSwitch = 1'b0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        repeat (200) step();
        RST_N = 1'b0;
        #1;
        check("midrst_acc", 64'(oAcc), 64'd0);
        check("midrst_busy", 64'(oBusy), 64'd0);
        check("midrst_done", 64'(oDone), 64'd0);
        step();
        RST_N = 1'b1;
        pulses = 0;
        for (int i = 0; i < T + 10; i++) begin
            step();
            if (oDone) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        check("midrst_busy_after", 64'(oBusy), 64'd0);
        run("after_rst", 1'b0, 1'b0, 1'b0, req);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
